// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// The scoreboard slot fields are sized for the default address and latency widths.
package hazard_pkg;
  localparam int MC_RD_W  = 6;
  localparam int MC_CNT_W = 6;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    LOAD_USE = 3'd1,
    MC_RAW   = 3'd2,
    MC_FULL  = 3'd3,
    REDIRECT = 3'd4,
    BUS      = 3'd5
  } hazard_e;

  typedef struct packed {
    logic                valid;
    logic [MC_RD_W-1:0]  rd;
    logic [MC_CNT_W-1:0] cnt;
  } mc_slot_t;

  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // x0 and f0 share index 0 below the file-select bit; neither is ever matched.
  function automatic logic reg_match(input logic [MC_RD_W-1:0] a,
                                     input logic [MC_RD_W-1:0] b,
                                     input logic               en);
    return en && (a == b) && (a[MC_RD_W-2:0] != {(MC_RD_W-1){1'b0}});
  endfunction
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: master is the pipeline, slave the hazard unit.
interface pipe_hazard_unit_if import hazard_pkg::*; #(
  parameter int REG_AW     = MC_RD_W,
  parameter int FWD_STAGES = 2,
  parameter int MC_SLOTS   = 4,
  parameter int LAT_W      = MC_CNT_W
);
  localparam int FSW = sel_width(FWD_STAGES);

  logic                         bus_stall;
  logic                         redirect;
  logic [REG_AW-1:0]            id_rs1;
  logic [REG_AW-1:0]            id_rs2;
  logic [REG_AW-1:0]            id_rd;
  logic                         id_use_rs1;
  logic                         id_use_rs2;
  logic                         id_we;
  logic                         mc_issue;
  logic [LAT_W-1:0]             mc_lat;
  logic [FWD_STAGES*REG_AW-1:0] prod_rd;
  logic [FWD_STAGES-1:0]        prod_we;
  logic                         ex_is_load;
  logic [FSW-1:0]               fwd_sel_rs1;
  logic [FSW-1:0]               fwd_sel_rs2;
  logic                         stall_if;
  logic                         stall_id;
  logic                         bubble_ex;
  logic                         flush_id;
  logic [MC_SLOTS-1:0]          mc_busy;
  logic                         mc_full;

  modport master (
    output bus_stall, redirect, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_we,
           mc_issue, mc_lat, prod_rd, prod_we, ex_is_load,
    input  fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_id, bubble_ex, flush_id, mc_busy, mc_full
  );

  modport slave (
    input  bus_stall, redirect, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_we,
           mc_issue, mc_lat, prod_rd, prod_we, ex_is_load,
    output fwd_sel_rs1, fwd_sel_rs2, stall_if, stall_id, bubble_ex, flush_id, mc_busy, mc_full
  );
endinterface

// File: rtl/pipe_hazard_unit_mc_scoreboard.sv
// Countdown scoreboard for outstanding multi-cycle results (MUL/DIV/FDIV).
// Counters run every cycle; allocation only takes slots already free at cycle start.
module mc_scoreboard import hazard_pkg::*; #(
  parameter int REG_AW   = MC_RD_W,
  parameter int LAT_W    = MC_CNT_W,
  parameter int MC_SLOTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc,
  input  logic [REG_AW-1:0]   alloc_rd,
  input  logic [LAT_W-1:0]    alloc_lat,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                use_rs1,
  input  logic                use_rs2,
  input  logic                id_we,
  output logic [MC_SLOTS-1:0] busy,
  output logic                full,
  output logic [MC_SLOTS-1:0] match
);
  mc_slot_t         slot_q [MC_SLOTS];
  mc_slot_t         slot_d [MC_SLOTS];
  logic             taken_s;
  logic [LAT_W-1:0] load_cnt_s;

  assign load_cnt_s = (alloc_lat == {LAT_W{1'b0}}) ? LAT_W'(1) : alloc_lat;

  // Slot next state: countdown/free for busy slots, lowest free slot takes an allocation.
  always_comb begin
    slot_d  = slot_q;
    taken_s = 1'b0;
    for (int i = 0; i < MC_SLOTS; i++) begin
      if (slot_q[i].valid) begin
        if (slot_q[i].cnt == MC_CNT_W'(1)) begin
          slot_d[i].valid = 1'b0;
          slot_d[i].cnt   = {MC_CNT_W{1'b0}};
        end else begin
          slot_d[i].cnt = slot_q[i].cnt - MC_CNT_W'(1);
        end
      end else if (alloc && !taken_s) begin
        slot_d[i].valid = 1'b1;
        slot_d[i].rd    = alloc_rd;
        slot_d[i].cnt   = load_cnt_s;
        taken_s         = 1'b1;
      end else begin
        slot_d[i] = slot_q[i];
      end
    end
  end

  // Occupancy and RAW/WAW match against the ID instruction.
  always_comb begin
    busy  = {MC_SLOTS{1'b0}};
    match = {MC_SLOTS{1'b0}};
    for (int i = 0; i < MC_SLOTS; i++) begin
      busy[i]  = slot_q[i].valid;
      match[i] = slot_q[i].valid &&
                 (reg_match(slot_q[i].rd, id_rs1, use_rs1) ||
                  reg_match(slot_q[i].rd, id_rs2, use_rs2) ||
                  reg_match(slot_q[i].rd, id_rd,  id_we));
    end
  end

  assign full = &busy;

  // Slot array register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MC_SLOTS; i++) begin
        slot_q[i] <= {$bits(mc_slot_t){1'b0}};
      end
    end else begin
      slot_q <= slot_d;
    end
  end
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: registered forwarding selects, combinational
// stall/bubble/flush arbitration, and a multi-cycle result scoreboard.
module pipe_hazard_unit import hazard_pkg::*; #(
  parameter int REG_AW     = MC_RD_W,
  parameter int FWD_STAGES = 2,
  parameter int MC_SLOTS   = 4,
  parameter int LAT_W      = MC_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_unit_if.slave  hif
);
  localparam int FSW = sel_width(FWD_STAGES);

  logic [FSW-1:0]      fwd_sel_rs1_q, fwd_sel_rs1_d, fwd_sel_rs2_q, fwd_sel_rs2_d;
  logic [FSW-1:0]      fwd1_s, fwd2_s;
  logic                lu_hold_q, lu_hold_d;
  logic [MC_SLOTS-1:0] mc_match_s, mc_busy_s;
  logic                mc_full_s;
  logic                lu_hz_s, raw_hz_s, full_hz_s, alloc_s;
  logic                stall_s, bubble_s, flush_s;
  hazard_e             cause_s, hz_s;

  mc_scoreboard #(.REG_AW(REG_AW), .LAT_W(LAT_W), .MC_SLOTS(MC_SLOTS)) u_sb (
    .clk(clk), .rst(rst), .alloc(alloc_s), .alloc_rd(hif.id_rd), .alloc_lat(hif.mc_lat),
    .id_rs1(hif.id_rs1), .id_rs2(hif.id_rs2), .id_rd(hif.id_rd),
    .use_rs1(hif.id_use_rs1), .use_rs2(hif.id_use_rs2), .id_we(hif.id_we),
    .busy(mc_busy_s), .full(mc_full_s), .match(mc_match_s)
  );

  // A load-use stall is taken once; lu_hold_q masks the repeat while the load drains.
  assign lu_hz_s = hif.ex_is_load && hif.prod_we[0] && !lu_hold_q &&
                   (reg_match(hif.prod_rd[REG_AW-1:0], hif.id_rs1, hif.id_use_rs1) ||
                    reg_match(hif.prod_rd[REG_AW-1:0], hif.id_rs2, hif.id_use_rs2));
  assign raw_hz_s  = |mc_match_s;
  assign full_hz_s = hif.mc_issue && mc_full_s;
  assign alloc_s   = hif.mc_issue && hif.id_we && (hz_s == NONE);

  // Priority arbitration; bus stall only freezes state, decisions below it still show.
  always_comb begin
    cause_s = NONE;
    if (hif.redirect) begin
      cause_s = REDIRECT;
    end else if (full_hz_s) begin
      cause_s = MC_FULL;
    end else if (raw_hz_s) begin
      cause_s = MC_RAW;
    end else if (lu_hz_s) begin
      cause_s = LOAD_USE;
    end else begin
      cause_s = NONE;
    end
    hz_s = hif.bus_stall ? BUS : cause_s;
  end

  // Pipeline control decode.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    case (cause_s)
      REDIRECT: begin
        flush_s  = 1'b1;
        bubble_s = 1'b1;
      end
      MC_FULL, MC_RAW, LOAD_USE: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end
      default: begin
        stall_s  = 1'b0;
        bubble_s = 1'b0;
        flush_s  = 1'b0;
      end
    endcase
  end

  // Forwarding: scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd1_s = {FSW{1'b0}};
    fwd2_s = {FSW{1'b0}};
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hif.prod_we[k] && reg_match(hif.prod_rd[k*REG_AW +: REG_AW], hif.id_rs1, hif.id_use_rs1)) begin
        fwd1_s = FSW'(k + 1);
      end else begin
        fwd1_s = fwd1_s;
      end
      if (hif.prod_we[k] && reg_match(hif.prod_rd[k*REG_AW +: REG_AW], hif.id_rs2, hif.id_use_rs2)) begin
        fwd2_s = FSW'(k + 1);
      end else begin
        fwd2_s = fwd2_s;
      end
    end
  end

  // Register next state.
  always_comb begin
    fwd_sel_rs1_d = fwd_sel_rs1_q;
    fwd_sel_rs2_d = fwd_sel_rs2_q;
    lu_hold_d     = lu_hold_q;
    if (hz_s == BUS) begin
      lu_hold_d = lu_hold_q;
    end else if (bubble_s) begin
      fwd_sel_rs1_d = {FSW{1'b0}};
      fwd_sel_rs2_d = {FSW{1'b0}};
      lu_hold_d     = (cause_s == LOAD_USE);
    end else begin
      fwd_sel_rs1_d = fwd1_s;
      fwd_sel_rs2_d = fwd2_s;
      lu_hold_d     = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_sel_rs1_q <= {FSW{1'b0}};
      fwd_sel_rs2_q <= {FSW{1'b0}};
      lu_hold_q     <= 1'b0;
    end else begin
      fwd_sel_rs1_q <= fwd_sel_rs1_d;
      fwd_sel_rs2_q <= fwd_sel_rs2_d;
      lu_hold_q     <= lu_hold_d;
    end
  end

  assign hif.fwd_sel_rs1 = fwd_sel_rs1_q;
  assign hif.fwd_sel_rs2 = fwd_sel_rs2_q;
  assign hif.stall_if    = stall_s;
  assign hif.stall_id    = stall_s;
  assign hif.bubble_ex   = bubble_s;
  assign hif.flush_id    = flush_s;
  assign hif.mc_busy     = mc_busy_s;
  assign hif.mc_full     = mc_full_s;
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the in-order integer/float pipeline, successor to the fixed two-stage controller hazard logic. Compares the ID-stage instruction against FWD_STAGES downstream producers and produces registered forwarding selects. Detects load-use hazards and tracks up to MC_SLOTS outstanding multi-cycle results (MUL/DIV/FDIV) in a countdown scoreboard. Arbitrates stall, bubble and flush against bus stalls and control-flow redirects.

## Interface
- REG_AW, 6: register address width; bit [REG_AW-1] set = float file; address 0 is integer x0.
- FWD_STAGES, 2: producer stages compared; index 0 = youngest (EX).
- MC_SLOTS, 4: outstanding multi-cycle result slots.
- LAT_W, 6: latency counter width.
- FSW, derived = $clog2(FWD_STAGES+1): forwarding select width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- bus_stall  in  1  memory bus not ready; freezes pipeline registers.
- redirect  in  1  taken branch / jump / interrupt resolved this cycle.
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID-stage source and destination addresses.
- id_use_rs1, id_use_rs2, id_we  in  1 each  operand/destination valid flags.
- mc_issue  in  1  ID instruction is multi-cycle.
- mc_lat  in  LAT_W  its result latency, in cycles.
- prod_rd  in  FWD_STAGES*REG_AW  producer destinations, slot k at [k*REG_AW +: REG_AW].
- prod_we  in  FWD_STAGES  producer writes a register.
- ex_is_load  in  1  producer slot 0 is a load (LW/FLW/…).
- fwd_sel_rs1, fwd_sel_rs2  out  FSW  0 = register file, k+1 = producer slot k.
- stall_if, stall_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_id  out  1  squash IF/ID contents.
- mc_busy  out  MC_SLOTS  slot-occupied vector.
- mc_full  out  1  all slots occupied.

## Operation
- Match rule: an address matches when it is equal, non-zero and the relevant write or use flag is set. A float address with value 0 is therefore never matchable.
- Forwarding: fwd_sel_rsX <= lowest k with prod_we[k] && prod_rd[k]==id_rsX && id_use_rsX, encoded as k+1; otherwise 0.
- Load-use hazard: ex_is_load && prod_we[0] && prod_rd[0] matches id_rs1 or id_rs2 (each gated by its use flag).
- MC hazard: any busy slot's rd matches id_rs1, id_rs2 or id_rd (RAW or WAW).
- MC full hazard: mc_issue && mc_full.
- Priority, highest first:
  - bus_stall: all registered outputs and slot allocation hold. Counters still decrement, because the functional units run independently.
  - redirect: flush_id=1, bubble_ex=1, stall_if=stall_id=0. Any pending load-use or MC stall is cancelled, and no slot is allocated.
  - MC / full hazard: stall_if=stall_id=1, bubble_ex=1.
  - load-use hazard: stall_if=stall_id=1, bubble_ex=1, for exactly one cycle.
- Scoreboard slot contents: valid, rd, cnt.
- Allocation happens when mc_issue && id_we && no stall && !redirect && !bus_stall. It takes the lowest-index slot free at the start of the cycle and loads cnt = max(mc_lat,1).
- Every valid slot decrements cnt each cycle. At cnt==1 the slot frees on the next edge.
- A slot freed this cycle is not reusable until the following cycle.
- On bubble_ex, both fwd_sel registers load 0.

## Timing
- Hazard decisions (stall_if, stall_id, bubble_ex, flush_id) are combinational from current inputs and scoreboard state.
- fwd_sel is registered: computed with the consumer in ID at cycle t, applied in EX at t+1.
- A load-use stall lasts 1 cycle. On the next cycle the load has advanced out of slot 0, so no repeat occurs.
- An MC RAW stall releases in the cycle after the slot frees: for latency L, the consumer leaves ID at issue+L+1.
- Reset values:
  - fwd_sel_rs1 = fwd_sel_rs2 = 0.
  - all slots invalid, counters 0; mc_busy = 0, mc_full = 0.
  - stall_if, stall_id, bubble_ex, flush_id = 0, since reset state holds no hazards and inputs are held at reset levels.
- Reset asserted mid-operation clears all slots immediately; no pending stall survives deassertion.

## Structure
- Package hazard_pkg holds:
  - hazard_e priority enum: NONE, LOAD_USE, MC_RAW, MC_FULL, REDIRECT, BUS.
  - mc_slot_t struct: valid, rd, cnt.
  - the FSW/clog2 helper function.
- Sub-module mc_scoreboard holds the slot array, allocate/decrement/free logic and the match vector. The top level holds forwarding, priority arbitration and outputs.

## Test plan
- Forwarding priority: prod_rd = {5,5}, both prod_we set, id_rs1=5 -> fwd_sel_rs1=1 the next cycle; with id_rs1=0 -> 0.
- Load-use: ex_is_load, prod_rd[0]=7, id_rs2=7 -> stall_if, stall_id, bubble_ex high for exactly 1 cycle. The same case with redirect high -> flush only, no stall.
- MC RAW: issue DIV rd=9, mc_lat=4; next instruction reads rs1=9 -> stalls 4 cycles, released at issue+5.
- Full scoreboard: MC_SLOTS=4, four issues with lat=20 -> mc_full=1; a fifth mc_issue stalls until the first slot frees.
- Bus stall: bus_stall high 3 cycles during an MC stall -> fwd_sel holds, while the countdown still completes on schedule.
- Reset: assert rst low with 3 slots busy -> mc_busy=0 immediately and all outputs 0.
